// File: rtl/mp_pkg.sv
// Shared definitions for the maxpool sequencer: sizes, FSM states, lane-wise max.
package mp_pkg;

   localparam int LANE_W = 8;
   localparam int DATA_W = 32;
   localparam int LANES  = DATA_W / LANE_W;
   localparam int MAX_W  = 416;
   localparam int ADDR_W = 9;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DRAIN
   } mp_state_e;

   // Per-lane signed maximum of two packed pixels.
   function automatic logic [DATA_W-1:0] lane_max(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         if ($signed(a[i*LANE_W +: LANE_W]) > $signed(b[i*LANE_W +: LANE_W]))
            r[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W];
         else
            r[i*LANE_W +: LANE_W] = b[i*LANE_W +: LANE_W];
      end
      return r;
   endfunction

endpackage

// File: rtl/mp_line_buf.sv
// One-row line buffer: two asynchronous read ports, one synchronous write port.
// A same-cycle read and write of one address returns the old contents.
module mp_line_buf
   import mp_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b
);

   logic [DATA_W-1:0] mem [MAX_W];

   // Write port; contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   assign rd_data_a = mem[rd_addr_a];
   assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/mp_pool_sequencer.sv
// Frame controller for the maxpool stage: consumes a raster pixel stream and
// emits 2x2 max-pooled pixels, either stride 2 or stride 1 with replicate padding.
module mp_pool_sequencer
   import mp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic [8:0]        cfg_width,
   input  logic [8:0]        cfg_height,
   input  logic              cfg_stride1,
   output logic              busy,
   output logic              done,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready
);

   mp_state_e         state_q, state_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic [ADDR_W-1:0] width_q, width_d;
   logic [ADDR_W-1:0] height_q, height_d;
   logic              stride1_q, stride1_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] v_prev_q, v_prev_d;
   logic              extra_pend_q, extra_pend_d;
   logic [DATA_W-1:0] extra_data_q, extra_data_d;
   logic [ADDR_W-1:0] flush_c_q, flush_c_d;
   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;

   logic              out_free;
   logic              in_hs;
   logic              last_col;
   logic              last_row;
   logic              flush_last;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic [DATA_W-1:0] v;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              load;
   logic [DATA_W-1:0] load_data;

   mp_line_buf u_line_buf (
      .clk       (clk),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_data_a (rd_data_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_b (rd_data_b)
   );

   assign out_free   = !m_valid_q || m_ready;
   assign s_ready    = (state_q == ST_RUN) && out_free && !extra_pend_q;
   assign in_hs      = s_valid && s_ready;
   assign last_col   = (col_q == width_q - 9'd1);
   assign last_row   = (row_q == height_q - 9'd1);
   assign flush_last = (flush_c_q == width_q - 9'd1);
   assign busy       = (state_q != ST_IDLE);
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;

   // Port A follows the raster column (halved in stride 2) or the flush column;
   // port B is the clamped right neighbour used by the bottom-row flush.
   always_comb begin
      rd_addr_a = col_q;
      if (state_q == ST_FLUSH)
         rd_addr_a = flush_c_q;
      else if (!stride1_q)
         rd_addr_a = col_q >> 1;
      rd_addr_b = flush_last ? flush_c_q : flush_c_q + 9'd1;
      v         = lane_max(rd_data_a, s_data);
   end

   // Next-state, counters, line buffer writes and output register loads.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      width_d      = width_q;
      height_d     = height_q;
      stride1_d    = stride1_q;
      hold_d       = hold_q;
      v_prev_d     = v_prev_q;
      extra_pend_d = extra_pend_q;
      extra_data_d = extra_data_q;
      flush_c_d    = flush_c_q;
      m_valid_d    = m_valid_q && !m_ready;
      m_data_d     = m_data_q;
      wr_en        = 1'b0;
      wr_addr      = rd_addr_a;
      wr_data      = '0;
      load         = 1'b0;
      load_data    = '0;
      done         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               width_d      = cfg_width;
               height_d     = cfg_height;
               stride1_d    = cfg_stride1;
               col_d        = '0;
               row_d        = '0;
               flush_c_d    = '0;
               extra_pend_d = 1'b0;
               state_d      = ST_RUN;
            end
         end

         ST_RUN: begin
            if (extra_pend_q) begin
               if (out_free) begin
                  load         = 1'b1;
                  load_data    = extra_data_q;
                  extra_pend_d = 1'b0;
               end
            end else if (in_hs) begin
               if (last_col) begin
                  col_d = '0;
                  row_d = last_row ? '0 : row_q + 9'd1;
               end else begin
                  col_d = col_q + 9'd1;
               end

               if (stride1_q) begin
                  wr_en   = 1'b1;
                  wr_addr = col_q;
                  wr_data = s_data;
                  if (row_q != '0) begin
                     v_prev_d = v;
                     if (col_q != '0) begin
                        load      = 1'b1;
                        load_data = lane_max(v_prev_q, v);
                     end
                     if (last_col) begin
                        extra_pend_d = 1'b1;
                        extra_data_d = v;
                     end
                  end
                  if (last_col && last_row)
                     state_d = ST_FLUSH;
               end else begin
                  if (!col_q[0]) begin
                     hold_d = s_data;
                  end else if (!row_q[0]) begin
                     wr_en   = 1'b1;
                     wr_addr = col_q >> 1;
                     wr_data = lane_max(hold_q, s_data);
                  end else begin
                     load      = 1'b1;
                     load_data = lane_max(lane_max(hold_q, s_data), rd_data_a);
                  end
                  if (last_col && last_row)
                     state_d = ST_DRAIN;
               end
            end
         end

         ST_FLUSH: begin
            if (out_free) begin
               load = 1'b1;
               if (extra_pend_q) begin
                  load_data    = extra_data_q;
                  extra_pend_d = 1'b0;
               end else begin
                  load_data = lane_max(rd_data_a, rd_data_b);
                  if (flush_last)
                     state_d = ST_DRAIN;
                  else
                     flush_c_d = flush_c_q + 9'd1;
               end
            end
         end

         ST_DRAIN: begin
            if (!m_valid_q) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         m_valid_d = 1'b1;
         m_data_d  = load_data;
      end
   end

   // State register with synchronous reset; a reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         width_q      <= '0;
         height_q     <= '0;
         stride1_q    <= 1'b0;
         hold_q       <= '0;
         v_prev_q     <= '0;
         extra_pend_q <= 1'b0;
         extra_data_q <= '0;
         flush_c_q    <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         width_q      <= width_d;
         height_q     <= height_d;
         stride1_q    <= stride1_d;
         hold_q       <= hold_d;
         v_prev_q     <= v_prev_d;
         extra_pend_q <= extra_pend_d;
         extra_data_q <= extra_data_d;
         flush_c_q    <= flush_c_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
      end
   end

endmodule

// File: tb/tb_mp_pool_sequencer.sv
// Self-checking bench for mp_pool_sequencer: a table of whole frames with
// hand-computed pooled outputs, plus signed-lane, backpressure and abort sequences.
module tb_mp_pool_sequencer;

   typedef logic [8:0][7:0] ev_t;

   typedef struct {
      int  w;
      int  h;
      bit  s1;
      int  nexp;
      ev_t expv;
      int  expStalls;
      int  stallPix;
      bit  chkLat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_start;
   logic [8:0]  cfg_width;
   logic [8:0]  cfg_height;
   logic        cfg_stride1;
   logic        busy;
   logic        done;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready;

   int          checks = 0;
   int          fails  = 0;
   logic [31:0] outQ[$];
   int          stallCnt;
   int          firstStallPix;
   int          doneLat;
   bit          doneSeen;
   vec_t        tbl[5];

   mp_pool_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_start   (cfg_start),
      .cfg_width   (cfg_width),
      .cfg_height  (cfg_height),
      .cfg_stride1 (cfg_stride1),
      .busy        (busy),
      .done        (done),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_ready     (m_ready)
   );

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] pixelOf(input int p, input int dmode);
      logic [7:0] b;
      if (dmode == 1)
         return (p == 0) ? 32'h807FFF00 : 32'h0;
      b = p[7:0];
      return {b, b, b, b};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Runs one frame: start pulse, raster pixels, output collection until done.
   task automatic applyStimulus(input int w, input int h, input bit s1,
                                input bit bp, input int dmode);
      int          p;
      int          total;
      int          lastOut;
      bit          prevV;
      bit          prevR;
      logic [31:0] prevD;
      bit          finished;
      outQ.delete();
      stallCnt      = 0;
      firstStallPix = -1;
      doneLat       = -1;
      doneSeen      = 1'b0;
      p             = 0;
      total         = w * h;
      lastOut       = -1;
      prevV         = 1'b0;
      prevR         = 1'b1;
      prevD         = '0;
      finished      = 1'b0;

      @(negedge clk);
      cfg_width   = 9'(w);
      cfg_height  = 9'(h);
      cfg_stride1 = s1;
      cfg_start   = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      checkOutput("busy_after_start", 32'(busy), 32'd1);

      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         m_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         s_valid = (p < total);
         s_data  = (p < total) ? pixelOf(p, dmode) : 32'h0;
         #1;
         if (bp) begin
            if (prevV && !prevR) begin
               checkOutput("stall_valid_held", 32'(m_valid), 32'd1);
               checkOutput("stall_data_held", m_data, prevD);
            end
            if (m_valid && !m_ready)
               checkOutput("s_ready_while_full", 32'(s_ready), 32'd0);
         end
         if (s_valid && !s_ready && !bp) begin
            stallCnt++;
            if (firstStallPix < 0)
               firstStallPix = p;
         end
         if (done) begin
            doneSeen = 1'b1;
            doneLat  = cyc - lastOut;
            finished = 1'b1;
         end
         if (s_valid && s_ready)
            p++;
         if (m_valid && m_ready) begin
            outQ.push_back(m_data);
            lastOut = cyc;
         end
         prevV = m_valid;
         prevR = m_ready;
         prevD = m_data;
         @(negedge clk);
      end

      checkOutput("done_seen", 32'(doneSeen), 32'd1);
      m_ready = 1'b1;
      s_valid = 1'b0;
      #1;
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("busy_after_done", 32'(busy), 32'd0);
   endtask

   task automatic checkFrame(input string tag, input int nexp, input ev_t ev);
      checkOutput({tag, "_count"}, 32'(outQ.size()), 32'(nexp));
      for (int k = 0; k < nexp && k < outQ.size(); k++)
         checkOutput($sformatf("%s_out%0d", tag, k), outQ[k], {4{ev[k]}});
   endtask

   initial begin
      int p;
      int doneCnt;

      tbl[0] = '{4, 4, 1'b0, 4, {40'd0, 8'd15, 8'd13, 8'd7, 8'd5}, 0, -1, 1'b1};
      tbl[1] = '{3, 3, 1'b1, 9, {8'd8, 8'd8, 8'd7, 8'd8, 8'd8, 8'd7, 8'd5, 8'd5, 8'd4},
                 1, 6, 1'b1};
      tbl[2] = '{5, 5, 1'b0, 4, {40'd0, 8'd18, 8'd16, 8'd8, 8'd6}, 0, -1, 1'b0};
      tbl[3] = '{2, 2, 1'b1, 4, {40'd0, 8'd3, 8'd3, 8'd3, 8'd3}, 0, -1, 1'b1};
      tbl[4] = '{3, 2, 1'b0, 1, {64'd0, 8'd4}, 0, -1, 1'b1};

      rst         = 1'b1;
      cfg_start   = 1'b0;
      cfg_width   = '0;
      cfg_height  = '0;
      cfg_stride1 = 1'b0;
      s_valid     = 1'b0;
      s_data      = '0;
      m_ready     = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_s_ready", 32'(s_ready), 32'd0);
      checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
      checkOutput("reset_m_data", m_data, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         $display("[TB] frame %0d: W=%0d H=%0d stride1=%0d", i, tbl[i].w, tbl[i].h, tbl[i].s1);
         applyStimulus(tbl[i].w, tbl[i].h, tbl[i].s1, 1'b0, 0);
         checkFrame($sformatf("tbl%0d", i), tbl[i].nexp, tbl[i].expv);
         checkOutput($sformatf("tbl%0d_stalls", i), 32'(stallCnt), 32'(tbl[i].expStalls));
         if (tbl[i].expStalls > 0)
            checkOutput($sformatf("tbl%0d_stall_pos", i), 32'(firstStallPix),
                        32'(tbl[i].stallPix));
         if (tbl[i].chkLat)
            checkOutput($sformatf("tbl%0d_done_latency", i), 32'(doneLat), 32'd1);
      end

      $display("[TB] signed lanes, stride 2, 2x2");
      applyStimulus(2, 2, 1'b0, 1'b0, 1);
      checkOutput("signed_count", 32'(outQ.size()), 32'd1);
      if (outQ.size() > 0)
         checkOutput("signed_out", outQ[0], 32'h007F0000);

      $display("[TB] backpressure, stride 2, 4x4");
      applyStimulus(4, 4, 1'b0, 1'b1, 0);
      checkFrame("bp", 4, {40'd0, 8'd15, 8'd13, 8'd7, 8'd5});
      checkOutput("bp_done_latency", 32'(doneLat), 32'd1);

      $display("[TB] reset mid-frame");
      @(negedge clk);
      cfg_width   = 9'd4;
      cfg_height  = 9'd4;
      cfg_stride1 = 1'b0;
      cfg_start   = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      m_ready   = 1'b1;
      p         = 0;
      for (int cyc = 0; cyc < 50 && p < 7; cyc++) begin
         s_valid = 1'b1;
         s_data  = pixelOf(p, 0);
         #1;
         if (s_ready)
            p++;
         @(negedge clk);
      end
      checkOutput("abort_inputs_taken", 32'(p), 32'd7);
      s_valid = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_m_valid", 32'(m_valid), 32'd0);
      checkOutput("abort_s_ready", 32'(s_ready), 32'd0);
      rst     = 1'b0;
      doneCnt = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         if (done)
            doneCnt++;
      end
      checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
      applyStimulus(4, 4, 1'b0, 1'b0, 0);
      checkFrame("after_abort", 4, {40'd0, 8'd15, 8'd13, 8'd7, 8'd5});

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
